// File: rtl/ppu_pkg.sv
// Shared PPU types and constants: the VRAM arbiter state encoding, the palette
// window base and the PPUCTRL bit that selects the v increment step.
package ppu_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        ACCESS  = 2'd2,
        CAPTURE = 2'd3
    } vram_arb_state_t;

    localparam logic [13:0] PAL_BASE_DEF  = 14'h3F00;
    localparam logic [13:0] PAL_NT_OFFSET = 14'h1000;
    localparam int unsigned PPUCTRL_INC   = 2;

endpackage

// File: rtl/ppu_vram_arb.sv
// VRAM port arbiter between the renderer fetch engine and CPU $2007 accesses,
// owning the PPUDATA read buffer, palette redirection and the v-increment pulse.
module ppu_vram_arb
    import ppu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 14,
    parameter logic [ADDR_W-1:0] PAL_BASE = PAL_BASE_DEF,
    parameter int unsigned       MEM_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              render_active,
    input  logic              rend_req,
    input  logic [ADDR_W-1:0] rend_addr,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [7:0]        cpu_wdata,
    input  logic [ADDR_W-1:0] v_addr,
    input  logic              inc32,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_busy,
    output logic              cpu_drop,
    input  logic              clr_drop,
    output logic              v_inc,
    output logic              v_inc32,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              pal_wr,
    input  logic [7:0]        pal_rdata
);

    vram_arb_state_t   state_r;
    vram_arb_state_t   state_s;
    logic              op_wr_r;
    logic [ADDR_W-1:0] addr_r;
    logic [7:0]        wdata_r;
    logic              inc32_r;
    logic [7:0]        rd_buf_r;
    logic              drop_r;
    logic              v_inc_r;
    logic              v_inc32_r;
    logic [1:0]        lat_cnt_r;

    logic              strobe_s;
    logic              busy_s;
    logic              v_pal_s;
    logic              accept_s;
    logic              pal_wr_s;
    logic              start_s;
    logic              bus_free_s;
    logic              capture_s;
    logic              inc_now_s;
    logic              inc_step_s;
    logic [ADDR_W-1:0] access_addr_s;

    assign strobe_s   = cpu_rd | cpu_wr;
    assign busy_s     = (state_r != IDLE);
    assign v_pal_s    = (v_addr >= PAL_BASE);
    assign accept_s   = strobe_s & ~busy_s;
    assign pal_wr_s   = accept_s & cpu_wr & v_pal_s;
    assign start_s    = accept_s & ~pal_wr_s;
    assign bus_free_s = ~render_active | ~rend_req;
    assign capture_s  = (state_r == CAPTURE) && (lat_cnt_r <= 2'd1);
    assign inc_now_s  = pal_wr_s | ((state_r == ACCESS) & op_wr_r) | capture_s;
    assign inc_step_s = pal_wr_s ? inc32 : inc32_r;

    // Palette reads fetch the nametable byte underneath to refill the read buffer.
    assign access_addr_s = (addr_r >= PAL_BASE) ? (addr_r - ADDR_W'(PAL_NT_OFFSET)) : addr_r;

    assign cpu_rdata = v_pal_s ? pal_rdata : rd_buf_r;
    assign cpu_busy  = busy_s;
    assign cpu_drop  = drop_r;
    assign v_inc     = v_inc_r;
    assign v_inc32   = v_inc32_r;
    assign pal_wr    = pal_wr_s;

    // Next-state logic for the CPU access sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_s = WAIT;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (bus_free_s) begin
                    state_s = ACCESS;
                end else begin
                    state_s = WAIT;
                end
            end
            ACCESS: begin
                if (op_wr_r) begin
                    state_s = IDLE;
                end else begin
                    state_s = CAPTURE;
                end
            end
            CAPTURE: begin
                if (capture_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = CAPTURE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Bus mux: renderer owns the port with zero added latency except in ACCESS.
    always_comb begin
        mem_addr  = rend_addr;
        mem_rd    = rend_req;
        mem_wr    = 1'b0;
        mem_wdata = 8'h00;
        if (state_r == ACCESS) begin
            mem_addr  = access_addr_s;
            mem_rd    = ~op_wr_r;
            mem_wr    = op_wr_r;
            mem_wdata = op_wr_r ? wdata_r : 8'h00;
        end else begin
            mem_addr  = rend_addr;
            mem_rd    = rend_req;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Request latch taken at the accepted strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_wr_r <= 1'b0;
            addr_r  <= '0;
            wdata_r <= 8'h00;
            inc32_r <= 1'b0;
        end else if (start_s) begin
            op_wr_r <= cpu_wr;
            addr_r  <= v_addr;
            wdata_r <= cpu_wdata;
            inc32_r <= inc32;
        end else begin
            op_wr_r <= op_wr_r;
        end
    end

    // Read latency counter: loaded on the read cycle, counts down while capturing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_cnt_r <= 2'd0;
        end else if (state_r == ACCESS) begin
            lat_cnt_r <= 2'(MEM_LAT);
        end else if ((state_r == CAPTURE) && (lat_cnt_r != 2'd0)) begin
            lat_cnt_r <= lat_cnt_r - 2'd1;
        end else begin
            lat_cnt_r <= lat_cnt_r;
        end
    end

    // PPUDATA read buffer, refilled only when the delayed VRAM data is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_buf_r <= 8'h00;
        end else if (capture_s) begin
            rd_buf_r <= mem_rdata;
        end else begin
            rd_buf_r <= rd_buf_r;
        end
    end

    // Single-cycle v increment pulse with its step size held alongside.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_inc_r   <= 1'b0;
            v_inc32_r <= 1'b0;
        end else begin
            v_inc_r   <= inc_now_s;
            v_inc32_r <= inc_now_s ? inc_step_s : 1'b0;
        end
    end

    // Sticky drop flag; a new drop beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_r <= 1'b0;
        end else if (strobe_s && busy_s) begin
            drop_r <= 1'b1;
        end else if (clr_drop) begin
            drop_r <= 1'b0;
        end else begin
            drop_r <= drop_r;
        end
    end

endmodule

// File: tb/tb_ppu_vram_arb.sv
// Self-checking bench for ppu_vram_arb: a transaction-level model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_ppu_vram_arb;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        render_active = 1'b0;
    logic        rend_req = 1'b0;
    logic [13:0] rend_addr = 14'h0000;
    logic        cpu_rd = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [7:0]  cpu_wdata = 8'h00;
    logic [13:0] v_addr = 14'h0000;
    logic        inc32 = 1'b0;
    logic        clr_drop = 1'b0;
    logic [7:0]  cpu_rdata, mem_wdata, mem_rdata, pal_rdata;
    logic [13:0] mem_addr;
    logic        cpu_busy, cpu_drop, v_inc, v_inc32, mem_rd, mem_wr, pal_wr;

    int checks = 0;
    int errors = 0;

    ppu_vram_arb #(.ADDR_W(14), .PAL_BASE(14'h3F00), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .render_active(render_active),
        .rend_req(rend_req), .rend_addr(rend_addr), .cpu_rd(cpu_rd),
        .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata), .v_addr(v_addr), .inc32(inc32),
        .cpu_rdata(cpu_rdata), .cpu_busy(cpu_busy), .cpu_drop(cpu_drop),
        .clr_drop(clr_drop), .v_inc(v_inc), .v_inc32(v_inc32),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .pal_wr(pal_wr),
        .pal_rdata(pal_rdata)
    );

    always #5 clk = ~clk;

    // VRAM with LAT-cycle read pipeline; data is valid only in the LAT-th cycle.
    logic [7:0]  vram [0:16383];
    logic [13:0] pa [0:LAT-1];
    logic        pv [0:LAT-1];

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                pv[i] <= 1'b0;
                pa[i] <= 14'h0000;
            end
        end else begin
            pv[0] <= mem_rd;
            pa[0] <= mem_addr;
            for (int i = 1; i < LAT; i++) begin
                pv[i] <= pv[i-1];
                pa[i] <= pa[i-1];
            end
        end
    end

    assign mem_rdata = pv[LAT-1] ? vram[pa[LAT-1]] : 8'h00;
    assign pal_rdata = 8'h2F + {3'b000, v_addr[4:0]};

    function automatic bit is_pal(input logic [13:0] a);
        return a >= 14'h3F00;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Transaction model: one outstanding CPU access, a pending increment and the buffer.
    bit          m_acc, m_go, m_iss, m_wr, m_inc, m_inc_p, m_inc32_p, m_drop;
    logic [13:0] m_addr;
    logic [7:0]  m_data, m_rbuf;
    int          m_wait;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_acc = 0; m_go = 0; m_iss = 0; m_wr = 0; m_inc = 0;
            m_inc_p = 0; m_inc32_p = 0; m_drop = 0;
            m_addr = 14'h0000; m_data = 8'h00; m_rbuf = 8'h00; m_wait = 0;
        end else begin
            bit strobe, ninc, ninc32;
            strobe = cpu_rd | cpu_wr;
            ninc = 0;
            ninc32 = 0;
            if (m_acc) begin
                if (strobe) m_drop = 1;
                else if (clr_drop) m_drop = 0;
                if (m_iss) begin
                    m_wait--;
                    if (m_wait == 0) begin
                        m_rbuf = vram[m_addr];
                        m_acc = 0; m_iss = 0;
                        ninc = 1; ninc32 = m_inc;
                    end
                end else if (m_go) begin
                    m_go = 0;
                    if (m_wr) begin
                        m_acc = 0; ninc = 1; ninc32 = m_inc;
                    end else begin
                        m_iss = 1; m_wait = LAT;
                    end
                end else if (!render_active || !rend_req) begin
                    m_go = 1;
                end
            end else begin
                if (clr_drop) m_drop = 0;
                if (strobe) begin
                    if (cpu_wr && is_pal(v_addr)) begin
                        ninc = 1; ninc32 = inc32;
                    end else begin
                        m_acc = 1; m_go = 0; m_iss = 0; m_wr = cpu_wr;
                        m_addr = (!cpu_wr && is_pal(v_addr)) ? v_addr - 14'h1000 : v_addr;
                        m_data = cpu_wdata; m_inc = inc32;
                    end
                end
            end
            m_inc_p = ninc;
            m_inc32_p = ninc32;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        bit on_bus;
        on_bus = m_acc && m_go;
        check("mem_addr",  32'(mem_addr),  32'(on_bus ? m_addr : rend_addr));
        check("mem_rd",    32'(mem_rd),    32'(on_bus ? !m_wr : rend_req));
        check("mem_wr",    32'(mem_wr),    32'(on_bus && m_wr));
        check("mem_wdata", 32'(mem_wdata), 32'((on_bus && m_wr) ? m_data : 8'h00));
        check("pal_wr",    32'(pal_wr),    32'(!m_acc && cpu_wr && is_pal(v_addr)));
        check("cpu_rdata", 32'(cpu_rdata), 32'(is_pal(v_addr) ? pal_rdata : m_rbuf));
        check("cpu_busy",  32'(cpu_busy),  32'(m_acc));
        check("cpu_drop",  32'(cpu_drop),  32'(m_drop));
        check("v_inc",     32'(v_inc),     32'(m_inc_p));
        check("v_inc32",   32'(v_inc32),   32'(m_inc32_p));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) vram[i] = 8'(i) ^ 8'hA5;
        vram[14'h2400] = 8'h11;
        vram[14'h2401] = 8'h22;
        vram[14'h2F01] = 8'h77;

        // Reset state
        tick(3);
        check("rst_busy", 32'(cpu_busy), 32'd0);
        check("rst_rdata", 32'(cpu_rdata), 32'h00);
        check("rst_vinc", 32'(v_inc), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // 1: simple write at $2000
        v_addr = 14'h2000; cpu_wdata = 8'h5A; inc32 = 1'b0; cpu_wr = 1'b1;
        tick(1);
        cpu_wr = 1'b0;
        check("t1_busy", 32'(cpu_busy), 32'd1);
        tick(1);
        check("t1_mem_wr", 32'(mem_wr), 32'd1);
        check("t1_addr", 32'(mem_addr), 32'h2000);
        check("t1_wdata", 32'(mem_wdata), 32'h5A);
        tick(1);
        check("t1_vinc", 32'(v_inc), 32'd1);
        check("t1_vinc32", 32'(v_inc32), 32'd0);
        check("t1_mem_wr_once", 32'(mem_wr), 32'd0);

        // Palette write with increment-by-32
        v_addr = 14'h3F05; cpu_wdata = 8'h12; inc32 = 1'b1; cpu_wr = 1'b1;
        #1;
        check("pw_pal_wr", 32'(pal_wr), 32'd1);
        check("pw_no_mem", 32'(mem_wr), 32'd0);
        tick(1);
        cpu_wr = 1'b0; inc32 = 1'b0;
        check("pw_vinc", 32'(v_inc), 32'd1);
        check("pw_vinc32", 32'(v_inc32), 32'd1);
        check("pw_idle", 32'(cpu_busy), 32'd0);
        tick(2);

        // 2: read buffer lag
        v_addr = 14'h2400; cpu_rd = 1'b1;
        #1;
        check("t2_first", 32'(cpu_rdata), 32'h00);
        tick(1);
        cpu_rd = 1'b0;
        tick(5);
        check("t2_vinc", 32'(v_inc), 32'd1);
        v_addr = 14'h2401; cpu_rd = 1'b1;
        #1;
        check("t2_second", 32'(cpu_rdata), 32'h11);
        tick(1);
        cpu_rd = 1'b0;
        tick(5);
        v_addr = 14'h2402;
        #1;
        check("t2_buf", 32'(cpu_rdata), 32'h22);

        // 3: palette read
        v_addr = 14'h3F01; cpu_rd = 1'b1;
        #1;
        check("t3_pal", 32'(cpu_rdata), 32'h30);
        tick(1);
        cpu_rd = 1'b0;
        tick(1);
        check("t3_mem_rd", 32'(mem_rd), 32'd1);
        check("t3_addr", 32'(mem_addr), 32'h2F01);
        tick(4);
        v_addr = 14'h0000;
        #1;
        check("t3_buf", 32'(cpu_rdata), 32'h77);

        // 4: renderer busy, CPU waits
        render_active = 1'b1; v_addr = 14'h2123; cpu_wdata = 8'hC3;
        for (int i = 0; i < 20; i++) begin
            rend_req = 1'b1;
            rend_addr = 14'h0100 + 14'(i * 3);
            cpu_wr = (i == 2);
            #1;
            if (i == 12) begin
                check("t4_busy", 32'(cpu_busy), 32'd1);
                check("t4_track", 32'(mem_addr), 32'h0124);
            end
            tick(1);
        end
        cpu_wr = 1'b0; rend_req = 1'b0;
        tick(1);
        check("t4_mem_wr", 32'(mem_wr), 32'd1);
        check("t4_addr", 32'(mem_addr), 32'h2123);
        check("t4_wdata", 32'(mem_wdata), 32'hC3);
        tick(1);
        check("t4_vinc", 32'(v_inc), 32'd1);

        // 5: drop while busy, clear, set-wins, rd+wr together
        rend_req = 1'b1; v_addr = 14'h2200; cpu_wdata = 8'h44; cpu_wr = 1'b1;
        tick(1);
        cpu_wdata = 8'h99;
        tick(1);
        cpu_wr = 1'b0;
        check("t5_drop", 32'(cpu_drop), 32'd1);
        tick(2);
        rend_req = 1'b0;
        tick(1);
        check("t5_wdata", 32'(mem_wdata), 32'h44);
        tick(1);
        check("t5_drop_held", 32'(cpu_drop), 32'd1);
        clr_drop = 1'b1;
        tick(1);
        clr_drop = 1'b0;
        check("t5_cleared", 32'(cpu_drop), 32'd0);
        rend_req = 1'b1; v_addr = 14'h2201; cpu_rd = 1'b1;
        tick(1);
        cpu_rd = 1'b0; clr_drop = 1'b1; cpu_wr = 1'b1;
        tick(1);
        clr_drop = 1'b0; cpu_wr = 1'b0;
        check("t5_set_wins", 32'(cpu_drop), 32'd1);
        rend_req = 1'b0;
        tick(8);
        clr_drop = 1'b1;
        tick(1);
        clr_drop = 1'b0;
        render_active = 1'b0;
        v_addr = 14'h2300; cpu_wdata = 8'h5C; cpu_rd = 1'b1; cpu_wr = 1'b1;
        tick(1);
        cpu_rd = 1'b0; cpu_wr = 1'b0;
        tick(1);
        check("t5_wr_only", 32'(mem_wr), 32'd1);
        check("t5_no_rd", 32'(mem_rd), 32'd0);
        check("t5_rw_addr", 32'(mem_addr), 32'h2300);
        tick(3);

        // 6: reset during CAPTURE
        v_addr = 14'h2400; cpu_rd = 1'b1;
        tick(1);
        cpu_rd = 1'b0;
        tick(2);
        rst_n = 1'b0;
        #1;
        check("t6_busy", 32'(cpu_busy), 32'd0);
        check("t6_rdata", 32'(cpu_rdata), 32'h00);
        check("t6_mem_rd", 32'(mem_rd), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(8);
        check("t6_no_vinc", 32'(v_inc), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
